// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit
//
// Stall and flush controller for the 5-stage RISC-V core. Finds the cases
// where an operand cannot be forwarded yet (load-use, and operands of
// ID-resolved branch/jalr still being produced). A small FSM sequences the
// two-cycle stall of a load feeding a branch/jalr. Memory stalls freeze the
// whole pipe. Redirects resolved in ID flush IF/ID.
//
// Optional feature: define HAZARD_PERF_EN to add saturating stall/flush
// performance counters (perf_stall_cnt, perf_flush_cnt, PERF_W bits each).
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   rs1, rs2, use_rs1, use_rs2    ID instruction sources and read enables
//   branch, jalr, redirect        ID control-flow info
//   ID_EX_rd/_regwrite/_memread   EX instruction destination info
//   EX_MEM_rd/_memread            MEM instruction destination info
//   mem_stall                     cache busy, freezes the pipe
//   pc_write, IF_ID_write         front-end enables
//   ID_EX_bubble, IF_ID_flush     NOP insert into ID/EX, zero IF/ID
//   pipe_freeze                   hold every pipeline register
//
// state | meaning
// IDLE  | evaluate comparators; stall for the current cycle when needed
// STALL | second bubble cycle of a load feeding a branch/jalr operand

module hazard_detection_unit #(
   parameter int PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic              use_rs1,
   input  logic              use_rs2,
   input  logic              branch,
   input  logic              jalr,
   input  logic              redirect,
   input  logic [4:0]        ID_EX_rd,
   input  logic              ID_EX_regwrite,
   input  logic              ID_EX_memread,
   input  logic [4:0]        EX_MEM_rd,
   input  logic              EX_MEM_memread,
   input  logic              mem_stall,
   output logic              pc_write,
   output logic              IF_ID_write,
   output logic              ID_EX_bubble,
   output logic              IF_ID_flush,
   output logic              pipe_freeze
`ifdef HAZARD_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_stall_cnt,
   output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

   typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

   state_t     state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic [1:0] need;

   logic m_ex_rs1, m_ex_rs2, m_mem_rs1, m_mem_rs2;
   logic id_rs1, id_rs2;
   logic ex_feeds_id, mem_feeds_id, load_use;

   // Writes to x0 never create a dependency.
   assign m_ex_rs1  = ID_EX_regwrite && (ID_EX_rd != 5'd0) && (ID_EX_rd == rs1);
   assign m_ex_rs2  = ID_EX_regwrite && (ID_EX_rd != 5'd0) && (ID_EX_rd == rs2);
   assign m_mem_rs1 = EX_MEM_memread && (EX_MEM_rd != 5'd0) && (EX_MEM_rd == rs1);
   assign m_mem_rs2 = EX_MEM_memread && (EX_MEM_rd != 5'd0) && (EX_MEM_rd == rs2);

   // Operands consumed by the comparator/adder in ID.
   assign id_rs1 = branch || jalr;
   assign id_rs2 = branch;

   assign ex_feeds_id  = (id_rs1 && m_ex_rs1) || (id_rs2 && m_ex_rs2);
   assign mem_feeds_id = (id_rs1 && m_mem_rs1) || (id_rs2 && m_mem_rs2);
   assign load_use     = ID_EX_memread &&
                         ((use_rs1 && m_ex_rs1) || (use_rs2 && m_ex_rs2));

   always_comb begin
      need = 2'd0;
      if (ex_feeds_id && ID_EX_memread)
         need = 2'd2;
      else if (ex_feeds_id || mem_feeds_id || load_use)
         need = 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pc_write     = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_bubble = 1'b0;
      IF_ID_flush  = 1'b0;
      pipe_freeze  = 1'b0;
      if (!rst_n) begin
         pc_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_bubble = 1'b1;
      end else if (mem_stall) begin
         // Freeze holds state and cnt so no stall cycle is lost.
         pc_write    = 1'b0;
         IF_ID_write = 1'b0;
         pipe_freeze = 1'b1;
      end else if (state == STALL) begin
         // Redirect is ignored here: its operands are stale and ID is held.
         pc_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_bubble = 1'b1;
         if (cnt == 2'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
         end else begin
            cnt_nxt = cnt - 2'd1;
         end
      end else if (need != 2'd0) begin
         pc_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_bubble = 1'b1;
         if (need == 2'd2) begin
            state_nxt = STALL;
            cnt_nxt   = 2'd1;
         end
      end else begin
         IF_ID_flush = redirect;
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (ID_EX_bubble && (perf_stall_cnt != {PERF_W{1'b1}}))
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
         if (IF_ID_flush && (perf_flush_cnt != {PERF_W{1'b1}}))
            perf_flush_cnt <= perf_flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
// Output vector order: {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_freeze}

module tb_hazard_detection_unit;

   localparam logic [4:0] O_PASS   = 5'b11000;
   localparam logic [4:0] O_STALL  = 5'b00100;
   localparam logic [4:0] O_FREEZE = 5'b00001;
   localparam logic [4:0] O_FLUSH  = 5'b11010;
   localparam logic [4:0] O_RESET  = 5'b00100;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rs1, rs2, ID_EX_rd, EX_MEM_rd;
   logic       use_rs1, use_rs2, branch, jalr, redirect;
   logic       ID_EX_regwrite, ID_EX_memread, EX_MEM_memread, mem_stall;
   logic       pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_freeze;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
   logic [4:0] outs;

   int checks = 0;
   int errors = 0;

   assign outs = {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, pipe_freeze};

   always #5 clk = ~clk;

   hazard_detection_unit dut (
      .clk(clk), .rst_n(rst_n),
      .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
      .branch(branch), .jalr(jalr), .redirect(redirect),
      .ID_EX_rd(ID_EX_rd), .ID_EX_regwrite(ID_EX_regwrite),
      .ID_EX_memread(ID_EX_memread),
      .EX_MEM_rd(EX_MEM_rd), .EX_MEM_memread(EX_MEM_memread),
      .mem_stall(mem_stall),
      .pc_write(pc_write), .IF_ID_write(IF_ID_write),
      .ID_EX_bubble(ID_EX_bubble), .IF_ID_flush(IF_ID_flush),
      .pipe_freeze(pipe_freeze)
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   task automatic clear_inputs();
      rs1 = 5'd0; rs2 = 5'd0; use_rs1 = 1'b0; use_rs2 = 1'b0;
      branch = 1'b0; jalr = 1'b0; redirect = 1'b0;
      ID_EX_rd = 5'd0; ID_EX_regwrite = 1'b0; ID_EX_memread = 1'b0;
      EX_MEM_rd = 5'd0; EX_MEM_memread = 1'b0; mem_stall = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      #2;
      checks++;
      if (outs !== O_RESET) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=%b", outs, O_RESET);
      end
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_PASS) begin
         errors++;
         $display("FAIL reset_release got=%b exp=%b", outs, O_PASS);
      end
   endtask

   task automatic test_load_jalr();
      next_cycle();
      clear_inputs();
      ID_EX_memread = 1'b1; ID_EX_regwrite = 1'b1; ID_EX_rd = 5'd5;
      jalr = 1'b1; rs1 = 5'd5; use_rs1 = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_STALL) begin
         errors++;
         $display("FAIL ldjalr_c0 got=%b exp=%b", outs, O_STALL);
      end
      next_cycle();
      ID_EX_memread = 1'b0; ID_EX_regwrite = 1'b0; ID_EX_rd = 5'd0;
      EX_MEM_memread = 1'b1; EX_MEM_rd = 5'd5;
      redirect = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_STALL) begin
         errors++;
         $display("FAIL ldjalr_c1 got=%b exp=%b", outs, O_STALL);
      end
      next_cycle();
      EX_MEM_memread = 1'b0; EX_MEM_rd = 5'd0;
      @(negedge clk);
      checks++;
      if (outs !== O_FLUSH) begin
         errors++;
         $display("FAIL ldjalr_c2 got=%b exp=%b", outs, O_FLUSH);
      end
   endtask

   task automatic test_load_use();
      next_cycle();
      clear_inputs();
      ID_EX_memread = 1'b1; ID_EX_regwrite = 1'b1; ID_EX_rd = 5'd7;
      rs1 = 5'd2; rs2 = 5'd7; use_rs1 = 1'b1; use_rs2 = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_STALL) begin
         errors++;
         $display("FAIL loaduse_rs2 got=%b exp=%b", outs, O_STALL);
      end
      next_cycle();
      ID_EX_memread = 1'b0; ID_EX_regwrite = 1'b0; ID_EX_rd = 5'd0;
      @(negedge clk);
      checks++;
      if (outs !== O_PASS) begin
         errors++;
         $display("FAIL loaduse_one_bubble got=%b exp=%b", outs, O_PASS);
      end
      next_cycle();
      ID_EX_memread = 1'b1; ID_EX_regwrite = 1'b1; ID_EX_rd = 5'd0;
      rs1 = 5'd0; rs2 = 5'd0;
      @(negedge clk);
      checks++;
      if (outs !== O_PASS) begin
         errors++;
         $display("FAIL loaduse_x0 got=%b exp=%b", outs, O_PASS);
      end
      next_cycle();
      ID_EX_rd = 5'd9; rs1 = 5'd9; rs2 = 5'd4; use_rs1 = 1'b0; use_rs2 = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_PASS) begin
         errors++;
         $display("FAIL loaduse_unused got=%b exp=%b", outs, O_PASS);
      end
      next_cycle();
      use_rs1 = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_STALL) begin
         errors++;
         $display("FAIL loaduse_rs1 got=%b exp=%b", outs, O_STALL);
      end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_ex_alu();
      next_cycle();
      clear_inputs();
      ID_EX_regwrite = 1'b1; ID_EX_rd = 5'd3;
      branch = 1'b1; rs1 = 5'd3; rs2 = 5'd8; use_rs1 = 1'b1; use_rs2 = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_STALL) begin
         errors++;
         $display("FAIL alu_beq_rs1 got=%b exp=%b", outs, O_STALL);
      end
      next_cycle();
      ID_EX_regwrite = 1'b0; ID_EX_rd = 5'd0;
      @(negedge clk);
      checks++;
      if (outs !== O_PASS) begin
         errors++;
         $display("FAIL alu_one_bubble got=%b exp=%b", outs, O_PASS);
      end
      next_cycle();
      ID_EX_regwrite = 1'b1; ID_EX_rd = 5'd8;
      @(negedge clk);
      checks++;
      if (outs !== O_STALL) begin
         errors++;
         $display("FAIL alu_beq_rs2 got=%b exp=%b", outs, O_STALL);
      end
      next_cycle();
      branch = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== O_PASS) begin
         errors++;
         $display("FAIL alu_forwardable got=%b exp=%b", outs, O_PASS);
      end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_mem_load();
      next_cycle();
      clear_inputs();
      EX_MEM_memread = 1'b1; EX_MEM_rd = 5'd3;
      branch = 1'b1; rs1 = 5'd1; rs2 = 5'd3; use_rs1 = 1'b1; use_rs2 = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_STALL) begin
         errors++;
         $display("FAIL memload_beq got=%b exp=%b", outs, O_STALL);
      end
      next_cycle();
      EX_MEM_memread = 1'b0; EX_MEM_rd = 5'd0;
      @(negedge clk);
      checks++;
      if (outs !== O_PASS) begin
         errors++;
         $display("FAIL memload_one_bubble got=%b exp=%b", outs, O_PASS);
      end
      next_cycle();
      EX_MEM_memread = 1'b1; EX_MEM_rd = 5'd3; branch = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== O_PASS) begin
         errors++;
         $display("FAIL memload_alu_user got=%b exp=%b", outs, O_PASS);
      end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_freeze_in_stall();
      do_reset();
      ID_EX_memread = 1'b1; ID_EX_regwrite = 1'b1; ID_EX_rd = 5'd5;
      jalr = 1'b1; rs1 = 5'd5;
      @(negedge clk);
      checks++;
      if (outs !== O_STALL) begin
         errors++;
         $display("FAIL freeze_c0 got=%b exp=%b", outs, O_STALL);
      end
      next_cycle();
      clear_inputs();
      mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (outs !== O_FREEZE) begin
            errors++;
            $display("FAIL freeze_hold%0d got=%b exp=%b", i, outs, O_FREEZE);
         end
         if (i < 2) next_cycle();
      end
      next_cycle();
      mem_stall = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== O_STALL) begin
         errors++;
         $display("FAIL freeze_resume got=%b exp=%b", outs, O_STALL);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (outs !== O_PASS) begin
         errors++;
         $display("FAIL freeze_idle got=%b exp=%b", outs, O_PASS);
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (perf_stall_cnt !== 32'd2) begin
         errors++;
         $display("FAIL perf_stall got=%0d exp=2", perf_stall_cnt);
      end
`endif
   endtask

   task automatic test_flush();
      next_cycle();
      clear_inputs();
      redirect = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_FLUSH) begin
         errors++;
         $display("FAIL flush_plain got=%b exp=%b", outs, O_FLUSH);
      end
      next_cycle();
      mem_stall = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_FREEZE) begin
         errors++;
         $display("FAIL flush_frozen got=%b exp=%b", outs, O_FREEZE);
      end
      next_cycle();
      mem_stall = 1'b0;
      ID_EX_memread = 1'b1; ID_EX_regwrite = 1'b1; ID_EX_rd = 5'd6;
      rs1 = 5'd6; use_rs1 = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_STALL) begin
         errors++;
         $display("FAIL flush_stalled got=%b exp=%b", outs, O_STALL);
      end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_reset_mid_stall();
      next_cycle();
      clear_inputs();
      ID_EX_memread = 1'b1; ID_EX_regwrite = 1'b1; ID_EX_rd = 5'd5;
      branch = 1'b1; rs1 = 5'd5;
      next_cycle();
      clear_inputs();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (outs !== O_RESET) begin
         errors++;
         $display("FAIL midstall_reset got=%b exp=%b", outs, O_RESET);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (outs !== O_PASS) begin
         errors++;
         $display("FAIL midstall_release got=%b exp=%b", outs, O_PASS);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (outs !== O_PASS) begin
         errors++;
         $display("FAIL midstall_no_residual got=%b exp=%b", outs, O_PASS);
      end
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_load_jalr();
      test_load_use();
      test_ex_alu();
      test_mem_load();
      test_freeze_in_stall();
      test_flush();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Stall and flush controller for the 5-stage RISC-V core. It tells the pipeline when an operand cannot be forwarded yet and the front end must wait, the counterpart of the forwarding path, which picks the operand source once the value exists. It detects load-use hazards, and branch/jalr operands still in flight from a load. It sequences multi-cycle stalls with a small FSM, freezes the whole pipe on memory stalls, and issues IF/ID flushes on redirects.

## Interface
Parameters:
- `PERF_W`, default 32: width of the performance counters (only with `HAZARD_PERF_EN`).

Ports:
- `clk`  in  1  core clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rs1`, `rs2`  in  5 each  source registers of the instruction in ID
- `use_rs1`, `use_rs2`  in  1 each  ID instruction actually reads rs1 / rs2
- `branch`  in  1  ID holds a conditional branch, resolved in ID; reads rs1 and rs2
- `jalr`  in  1  ID holds a jalr; reads rs1
- `redirect`  in  1  ID resolved a taken branch, jal or jalr this cycle
- `ID_EX_rd`  in  5  destination register in EX
- `ID_EX_regwrite`, `ID_EX_memread`  in  1 each  EX instruction writes a register / is a load
- `EX_MEM_rd`  in  5  destination register in MEM
- `EX_MEM_memread`  in  1  MEM instruction is a load
- `mem_stall`  in  1  I-cache or D-cache busy
- `pc_write`  out  1  PC may update
- `IF_ID_write`  out  1  IF/ID may load
- `ID_EX_bubble`  out  1  insert a NOP into ID/EX
- `IF_ID_flush`  out  1  zero IF/ID
- `pipe_freeze`  out  1  hold every pipeline register
- `perf_stall_cnt`, `perf_flush_cnt`  out  PERF_W each  only with `HAZARD_PERF_EN`

## Operation
Match terms (a match never fires when the rd is 0):
- `mEX(r)` = `ID_EX_regwrite` and `ID_EX_rd` == r
- `mMEM(r)` = `EX_MEM_memread` and `EX_MEM_rd` == r
- ID-resolved operands: rs1 when `branch` or `jalr` is set; rs2 when `branch` is set.

Stall requirement, evaluated in IDLE only:
- Load in EX feeding an ID-resolved operand: `ID_EX_memread` and `mEX` → need = 2.
- Non-load in EX feeding an ID-resolved operand: `mEX` without `ID_EX_memread` → need = 1.
- Load in MEM feeding an ID-resolved operand: `mMEM` → need = 1.
- Ordinary load-use: `ID_EX_memread`, `mEX`, and `use_rs1`/`use_rs2` set → need = 1.
- Otherwise need = 0. When several terms hit, take the maximum.

FSM states:
- IDLE
  - need = 0: pass.
  - need ≥ 1: stall this cycle.
  - need = 2: next state STALL with cnt = 1.
- STALL
  - Stall unconditionally; comparators are ignored.
  - cnt == 1 → next state IDLE, cnt = 0.

Stall outputs: `pc_write`=0, `IF_ID_write`=0, `ID_EX_bubble`=1.

Freeze:
- When `mem_stall`=1: `pipe_freeze`=1, `pc_write`=0, `IF_ID_write`=0, `ID_EX_bubble`=0, `IF_ID_flush`=0.
- FSM state and cnt hold, so freeze overrides but does not consume stall cycles.

Flush:
- `IF_ID_flush` = `redirect` and not stalling and not frozen.
- Redirects during a stall are not trusted, because their operands are stale. ID is held, so the redirect re-presents after the stall.

## Timing
- All outputs are combinational from state plus inputs, in the same cycle as detection. The FSM is registered.
- Load-then-jalr back to back gives exactly 2 bubble cycles; the jalr leaves ID in the third cycle.
- A load-use hazard gives exactly 1 bubble.
- `mem_stall` asserted in STALL extends the stall by the freeze length; bubbles issued stay at 2.
- Reset (async, `rst_n`=0):
  - State = IDLE, cnt = 0, perf counters = 0.
  - Outputs are forced to `pc_write`=0, `IF_ID_write`=0, `ID_EX_bubble`=1, `IF_ID_flush`=0, `pipe_freeze`=0.
  - A mid-stall reset abandons the stall; the first cycle after release is evaluated as IDLE.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `perf_stall_cnt` increments each cycle with `ID_EX_bubble`=1 outside reset.
  - `perf_flush_cnt` increments each cycle with `IF_ID_flush`=1.
  - Both saturate at 2^PERF_W−1 and clear only on reset.
- Undefined: both counters and their ports are absent; stall/flush behaviour is identical.

## Test plan
- lw x5 in EX (`ID_EX_memread`=1, rd=5), jalr rs1=5 in ID → cycles 0 and 1 bubble=1, pc_write=0; cycle 2 pass; flush fires on `redirect` in cycle 2.
- lw x7 in EX, add with rs2=7 and use_rs2=1 in ID → exactly 1 bubble. Same with rd=0 → no stall.
- addi x3 in EX, beq rs1=3 → 1 bubble. lw x3 in MEM only → 1 bubble.
- STALL with cnt=1 plus `mem_stall` held for 3 cycles → pipe_freeze=1 for 3 cycles, then 1 more bubble, then IDLE; perf_stall_cnt = 2.
- `redirect`=1 with no hazard → IF_ID_flush=1 for that cycle. `redirect` with `mem_stall`=1 → flush=0.
- Pull rst_n low during STALL → outputs go to reset values immediately; after release, no residual bubble.
